// File: rtl/operand_fetch.sv
// operand_fetch: register file with a sequenced Rm-then-Rn operand fetch under a valid/ready handshake
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [1:0]        shift_in,
  input  logic              w_en,
  input  logic [REG_AW-1:0] w_num,
  input  logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out
);
  typedef enum logic [1:0] {IDLE, READ_B, READ_A, PRESENT} state_t;
  state_t state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [REG_AW-1:0] rn_q, rm_q;
  logic [1:0] shift_q;
  logic [DATA_W-1:0] rd_b, rd_a;
  logic take;
  // a same-cycle writeback to the register being read wins over the stored value
  assign rd_b = (w_en && w_num == rm_q) ? w_data : regs[rm_q];
  assign rd_a = (w_en && w_num == rn_q) ? w_data : regs[rn_q];
  assign take = start && (state == IDLE || (state == PRESENT && ready));
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      a_out <= '0;
      b_out <= '0;
      shift_out <= 2'b00;
      rn_q <= '0;
      rm_q <= '0;
      shift_q <= 2'b00;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (w_en) regs[w_num] <= w_data;
      if (take) begin
        rn_q <= rn;
        rm_q <= rm;
        shift_q <= shift_in;
      end
      case (state)
        IDLE: state <= take ? READ_B : IDLE;
        READ_B: begin
          b_out <= rd_b;
          state <= READ_A;
        end
        READ_A: begin
          a_out <= rd_a;
          shift_out <= shift_q;
          valid <= 1'b1;
          state <= PRESENT;
        end
        default: begin
          valid <= !ready;
          state <= !ready ? PRESENT : (start ? READ_B : IDLE);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed and randomized checks against a transaction-timing reference model
module tb_operand_fetch;
  logic clk = 0;
  logic reset, start, w_en, ready;
  logic [2:0] rn, rm, w_num;
  logic [1:0] shift_in, shift_out;
  logic [15:0] w_data, a_out, b_out;
  logic busy, valid;
  int checks = 0, errors = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .shift_in(shift_in),
    .w_en(w_en), .w_num(w_num), .w_data(w_data), .busy(busy), .valid(valid),
    .ready(ready), .a_out(a_out), .b_out(b_out), .shift_out(shift_out)
  );

  always #5 clk = ~clk;

  // reference: register contents plus one outstanding request accepted at edge acc
  logic [15:0] mregs [8];
  logic [15:0] ea, eb;
  logic [1:0] esh, qs;
  logic [2:0] qn, qm;
  logic live;
  int cyc = 0, acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // operands equal the register file as it stands just after the write of their fetch edge
  task automatic model_edge();
    logic presenting;
    cyc++;
    if (reset) begin
      foreach (mregs[i]) mregs[i] = '0;
      live = 0; ea = 0; eb = 0; esh = 0;
      return;
    end
    if (w_en) mregs[w_num] = w_data;
    if (live && cyc == acc + 1) eb = mregs[qm];
    if (live && cyc == acc + 2) begin
      ea = mregs[qn];
      esh = qs;
    end
    presenting = live && cyc > acc + 2;
    if ((!live || (presenting && ready)) && start) begin
      live = 1; acc = cyc; qn = rn; qm = rm; qs = shift_in;
    end else if (presenting && ready) live = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("valid", valid, live && cyc >= acc + 2);
    check("busy", busy, live);
    check("a_out", a_out, ea);
    check("b_out", b_out, eb);
    check("shift_out", shift_out, esh);
  endtask

  task automatic drive(input logic st, input logic [2:0] n, input logic [2:0] m, input logic [1:0] sh,
                       input logic we, input logic [2:0] wn, input logic [15:0] wd, input logic rdy);
    start = st; rn = n; rm = m; shift_in = sh; w_en = we; w_num = wn; w_data = wd; ready = rdy;
    step();
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = 'x;
    live = 0; ea = 'x; eb = 'x; esh = 'x;
    reset = 1;
    drive(0, 0, 0, 0, 1, 3, 16'hDEAD, 0);
    check("rst_valid", valid, 0);
    check("rst_a", a_out, 0);
    reset = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_valid", valid, 1);
    check("t1_b", b_out, 16'h0000);
    drive(0, 0, 0, 0, 1, 3, 16'h1234, 1);
    check("t1_idle", busy, 0);
    drive(0, 0, 0, 0, 1, 5, 16'h8001, 0);
    drive(0, 0, 0, 0, 1, 1, 16'hA1A1, 0);
    drive(0, 0, 0, 0, 1, 2, 16'hB2B2, 0);
    drive(1, 3, 5, 2'b11, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_early", valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t2_valid", valid, 1);
    check("t2_a", a_out, 16'h1234);
    check("t2_b", b_out, 16'h8001);
    check("t2_sh", shift_out, 2'b11);
    for (int i = 0; i < 4; i++) drive(i[0], 7, 7, 0, 1, 5, 16'hFFFF, 0);
    check("t3_valid", valid, 1);
    check("t3_a", a_out, 16'h1234);
    check("t3_b", b_out, 16'h8001);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("t2_idle", busy, 0);
    drive(1, 3, 5, 2'b01, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 16'hBEEF, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t4_bypass", b_out, 16'hBEEF);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 3, 5, 2'b10, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 16'h1111, 0);
    check("t4_late", b_out, 16'hBEEF);
    drive(1, 1, 2, 2'b00, 0, 0, 0, 1);
    check("t5_busy", busy, 1);
    check("t5_nvalid", valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t5_a", a_out, 16'hA1A1);
    check("t5_b", b_out, 16'hB2B2);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 3, 5, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 0;
    check("t6_valid", valid, 0);
    check("t6_busy", busy, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
    check("t6_stale", valid, 0);
    drive(1, 3, 5, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("t6_a", a_out, 16'h0000);
    check("t6_b", b_out, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(63) == 0);
      drive($urandom_range(1), 3'($urandom), 3'($urandom), 2'($urandom),
            $urandom_range(1), 3'($urandom), 16'($urandom), $urandom_range(1));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
